key_mode_ctrl: RTL and testbench

- Upstream control stage for the colour-bar picture generator.
- Synchronises and debounces the four board keys (key_s, key_d, key_f, key_g) in the pixel clock domain, and turns each press into a one-cycle pulse.
- Maintains the display state that the picture generator consumes: pattern mode, horizontal scroll offset and pause flag.
- Scroll advances once per frame on the frame_tick pulse supplied by the VGA timing stage.

---
 rtl/key_mode_ctrl.sv | 172 +++++++++++++++++
 tb/tb_key_mode_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_mode_ctrl.sv
// ---------------------------------------------------------------------------
// key_mode_ctrl
//
// Control stage ahead of the colour-bar picture generator. It synchronises and
// debounces the four board keys in the pixel clock domain and turns each press
// into a one-cycle pulse. It also holds the display state the generator reads:
// pattern mode, horizontal scroll offset and pause flag.
//
// Optional build macro: KEY_MODE_AUTO_CYCLE_EN
//   defined   - a frame counter advances the mode every AUTO_FRAMES unpaused
//               frames; any key pulse restarts the count.
//   undefined - mode changes only on key presses.
//
// Ports
//   vga_clk    in   1   pixel clock, the only clock
//   sys_rst    in   1   synchronous active-high reset
//   key_s      in   1   raw key, active-low, async: next mode
//   key_d      in   1   raw key, active-low, async: previous mode
//   key_f      in   1   raw key, active-low, async: toggle pause
//   key_g      in   1   raw key, active-low, async: clear scroll
//   frame_tick in   1   one-cycle pulse per frame
//   mode       out  2   current pattern select
//   scroll_x   out  10  horizontal offset, 0..H_VALID-1
//   paused     out  1   1 = scroll frozen
//   key_pulse  out  4   registered press pulses {g,f,d,s}
// ---------------------------------------------------------------------------
module key_mode_ctrl #(
    parameter int DEB_CNT     = 499_999,
    parameter int H_VALID     = 640,
    parameter int SCROLL_STEP = 2,
    parameter int NUM_MODES   = 4,
    parameter int AUTO_FRAMES = 300
) (
    input  logic       vga_clk,
    input  logic       sys_rst,
    input  logic       key_s,
    input  logic       key_d,
    input  logic       key_f,
    input  logic       key_g,
    input  logic       frame_tick,
    output logic [1:0] mode,
    output logic [9:0] scroll_x,
    output logic       paused,
    output logic [3:0] key_pulse
);

    localparam int CNT_W = $clog2(DEB_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CNT);

    // Elaboration-time sanity checks on the configuration.
    if (NUM_MODES < 1 || NUM_MODES > 4 || H_VALID > 1024 || H_VALID < 1 ||
        SCROLL_STEP >= H_VALID || AUTO_FRAMES < 1) begin : g_bad_cfg
        $error("key_mode_ctrl: unsupported parameter combination");
    end

    logic [3:0]       w_keys_raw;
    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [3:0]       r_stable;
    logic [CNT_W-1:0] r_cnt [4];
    logic [3:0]       r_key_pulse;
    logic [1:0]       r_mode;
    logic [9:0]       r_scroll;
    logic             r_paused;

    logic             w_up;
    logic             w_dn;
    logic             w_auto;
    logic [1:0]       w_mode_inc;
    logic [1:0]       w_mode_dec;
    logic [10:0]      w_sum;
    logic [9:0]       w_scroll_next;

    assign w_keys_raw = {key_g, key_f, key_d, key_s};

    // Per-key 2-FF synchroniser and debounce. The stable level only follows
    // the synchronised level after it has differed for DEB_CNT+1 consecutive
    // cycles; a press pulse is issued on the same edge the stable level falls.
    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            r_sync1     <= 4'hF;
            r_sync2     <= 4'hF;
            r_stable    <= 4'hF;
            r_key_pulse <= 4'h0;
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_keys_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 4; i++) begin
                r_key_pulse[i] <= 1'b0;
                if (r_sync2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_stable[i]    <= r_sync2[i];
                    r_cnt[i]       <= '0;
                    r_key_pulse[i] <= ~r_sync2[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Simultaneous next/previous presses cancel each other.
    assign w_up       = r_key_pulse[0] & ~r_key_pulse[1];
    assign w_dn       = r_key_pulse[1] & ~r_key_pulse[0];
    assign w_mode_inc = (r_mode == 2'(NUM_MODES - 1)) ? 2'd0 : r_mode + 2'd1;
    assign w_mode_dec = (r_mode == 2'd0) ? 2'(NUM_MODES - 1) : r_mode - 2'd1;

    // Sum is 11 bits so the wrap compare cannot overflow near H_VALID.
    assign w_sum         = {1'b0, r_scroll} + 11'(SCROLL_STEP);
    assign w_scroll_next = (w_sum >= 11'(H_VALID)) ? 10'(w_sum - 11'(H_VALID))
                                                   : w_sum[9:0];

`ifdef KEY_MODE_AUTO_CYCLE_EN
    localparam int FCNT_W = $clog2(AUTO_FRAMES + 1);
    logic [FCNT_W-1:0] r_frame_cnt;

    // Auto step fires on the tick that completes AUTO_FRAMES unpaused frames,
    // unless a key pulse is present (keys restart the count and take priority).
    assign w_auto = frame_tick & ~r_paused & (r_key_pulse == 4'h0) &
                    (r_frame_cnt == FCNT_W'(AUTO_FRAMES - 1));

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            r_frame_cnt <= '0;
        end else if (r_key_pulse != 4'h0) begin
            r_frame_cnt <= '0;
        end else if (frame_tick && !r_paused) begin
            r_frame_cnt <= w_auto ? '0 : r_frame_cnt + FCNT_W'(1);
        end
    end
`else
    assign w_auto = 1'b0;
`endif

    // Display state. Mode and pause act on the registered pulses, so they
    // update the cycle after key_pulse. Scroll step uses the pre-toggle pause.
    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            r_mode   <= 2'd0;
            r_scroll <= 10'd0;
            r_paused <= 1'b0;
        end else begin
            if (w_up) begin
                r_mode <= w_mode_inc;
            end else if (w_dn) begin
                r_mode <= w_mode_dec;
            end else if (w_auto) begin
                r_mode <= w_mode_inc;
            end

            if (r_key_pulse[2]) begin
                r_paused <= ~r_paused;
            end

            if (r_key_pulse[3]) begin
                r_scroll <= 10'd0;
            end else if (frame_tick && !r_paused) begin
                r_scroll <= w_scroll_next;
            end
        end
    end

    assign mode      = r_mode;
    assign scroll_x  = r_scroll;
    assign paused    = r_paused;
    assign key_pulse = r_key_pulse;

endmodule

// File: tb/tb_key_mode_ctrl.sv
// ---------------------------------------------------------------------------
// tb_key_mode_ctrl
//
// Directed bench for key_mode_ctrl with DEB_CNT=15 and AUTO_FRAMES=4. A second
// instance with SCROLL_STEP=6 shares all inputs to exercise a different wrap.
// ---------------------------------------------------------------------------
module tb_key_mode_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] keys = 4'hF;   // {g,f,d,s}, active-low
    logic       ft = 1'b0;

    logic [1:0] mode, mode6;
    logic [9:0] scroll, scroll6;
    logic       paused, paused6;
    logic [3:0] kp, kp6;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    key_mode_ctrl #(
        .DEB_CNT(15), .H_VALID(640), .SCROLL_STEP(2), .NUM_MODES(4), .AUTO_FRAMES(4)
    ) u_dut (
        .vga_clk(clk), .sys_rst(rst),
        .key_s(keys[0]), .key_d(keys[1]), .key_f(keys[2]), .key_g(keys[3]),
        .frame_tick(ft), .mode(mode), .scroll_x(scroll), .paused(paused),
        .key_pulse(kp)
    );

    key_mode_ctrl #(
        .DEB_CNT(15), .H_VALID(640), .SCROLL_STEP(6), .NUM_MODES(4), .AUTO_FRAMES(4)
    ) u_dut6 (
        .vga_clk(clk), .sys_rst(rst),
        .key_s(keys[0]), .key_d(keys[1]), .key_f(keys[2]), .key_g(keys[3]),
        .frame_tick(ft), .mode(mode6), .scroll_x(scroll6), .paused(paused6),
        .key_pulse(kp6)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            ft = 1'b1;
            @(negedge clk);
            ft = 1'b0;
            @(negedge clk);
        end
    endtask

    // Hold the masked keys low for 40 cycles, then release for 24 cycles.
    // Reports the pulse count, the cycle of the first pulse and its pattern.
    task automatic press(input logic [3:0] mask, output int np, output int lat,
                         output logic [3:0] first);
        np = 0; lat = 0; first = 4'h0;
        keys = keys & ~mask;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (kp != 4'h0) begin
                np++;
                if (lat == 0) begin
                    lat = i;
                    first = kp;
                end
            end
        end
        keys = keys | mask;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (kp != 4'h0) np++;
        end
    endtask

    // Press the masked keys and raise frame_tick in the cycle the pulse is out.
    task automatic press_with_tick(input logic [3:0] mask, output int hit);
        hit = 0;
        keys = keys & ~mask;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (kp != 4'h0 && hit == 0) begin
                hit = 1;
                ft = 1'b1;
                @(negedge clk);
                ft = 1'b0;
            end
        end
        keys = keys | mask;
        repeat (24) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int np, lat, hit;
        logic [3:0] first;

        // Reset state
        rst = 1'b1;
        cyc(3);
        check("rst_mode", mode, 0);
        check("rst_scroll", scroll, 0);
        check("rst_paused", paused, 0);
        check("rst_pulse", kp, 0);
        rst = 1'b0;
        cyc(2);

        // Single held key_s: one pulse at 17..19 cycles, mode 0 -> 1
        press(4'b0001, np, lat, first);
        check("s_npulse", np, 1);
        check("s_latency_17_19", (lat >= 17 && lat <= 19), 1);
        check("s_pulse_bit", first, 4'b0001);
        check("s_mode", mode, 1);
        check("s_scroll", scroll, 0);
        check("s_paused", paused, 0);

        // Short glitches on key_d are rejected
        np = 0;
        for (int j = 0; j < 10; j++) begin
            keys[1] = 1'b0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                if (kp != 4'h0) np++;
            end
            keys[1] = 1'b1;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                if (kp != 4'h0) np++;
            end
        end
        cyc(20);
        check("glitch_npulse", np, 0);
        check("glitch_mode", mode, 1);

        // Clean key_d presses: 1 -> 0 -> 3 (wrap)
        press(4'b0010, np, lat, first);
        check("d_mode_0", mode, 0);
        press(4'b0010, np, lat, first);
        check("d_npulse", np, 1);
        check("d_mode_wrap", mode, 3);

        // s and d pressed together: both pulses, mode unchanged
        press(4'b0011, np, lat, first);
        check("sd_npulse", np, 1);
        check("sd_pulse_bits", first, 4'b0011);
        check("sd_mode", mode, 3);

        // Auto mode cycling
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(1);
`ifdef KEY_MODE_AUTO_CYCLE_EN
        ticks(4);
        check("auto_4", mode, 1);
        ticks(4);
        check("auto_8", mode, 2);
        ticks(2);
        press(4'b0100, np, lat, first);
        press(4'b0100, np, lat, first);
        check("auto_unpaused", paused, 0);
        ticks(3);
        check("auto_restart_3", mode, 2);
        ticks(1);
        check("auto_restart_4", mode, 3);
`else
        ticks(20);
        check("noauto_mode", mode, 0);
        check("noauto_scroll", scroll, 40);
`endif

        // Scroll stepping and wrap
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(1);
        ticks(8);
        check("scr_8", scroll, 16);
        check("scr6_8", scroll6, 48);
        ticks(98);
        check("scr_106", scroll, 212);
        check("scr6_636", scroll6, 636);
        ticks(1);
        check("scr_107", scroll, 214);
        check("scr6_wrap_2", scroll6, 2);
        ticks(212);
        check("scr_638", scroll, 638);
        check("scr6_319", scroll6, 634);
        ticks(1);
        check("scr_wrap_0", scroll, 0);
        check("scr6_320", scroll6, 0);

        // Pause freezes scroll, key_g clears it
        ticks(5);
        check("scr_pre_pause", scroll, 10);
        press(4'b0100, np, lat, first);
        check("pause_on", paused, 1);
        ticks(5);
        check("pause_frozen", scroll, 10);
        check("pause6_frozen", scroll6, 30);
        press(4'b1000, np, lat, first);
        check("g_clear", scroll, 0);
        check("g_clear6", scroll6, 0);
        check("g_paused_kept", paused, 1);

        // g pulse coincident with frame_tick: clear wins
        press(4'b0100, np, lat, first);
        check("pause_off", paused, 0);
        ticks(3);
        check("scr_pre_gtick", scroll, 6);
        press_with_tick(4'b1000, hit);
        check("gtick_hit", hit, 1);
        check("gtick_scroll", scroll, 0);
        check("gtick_scroll6", scroll6, 0);

        // f pulse coincident with frame_tick: step uses old paused=0
        press_with_tick(4'b0100, hit);
        check("ftick_hit", hit, 1);
        check("ftick_scroll", scroll, 2);
        check("ftick_scroll6", scroll6, 6);
        check("ftick_paused", paused, 1);

        // Reset during an active debounce count
        keys[0] = 1'b0;
        cyc(8);
        rst = 1'b1;
        keys[0] = 1'b1;
        cyc(2);
        rst = 1'b0;
        check("midrst_mode", mode, 0);
        check("midrst_scroll", scroll, 0);
        check("midrst_paused", paused, 0);
        check("midrst_pulse", kp, 0);
        np = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (kp != 4'h0) np++;
        end
        check("midrst_no_pulse", np, 0);
        check("midrst_mode_after", mode, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
